// File: rtl/alu_muldiv_unit_pkg.sv
// Shared opcode encoding, issue-FSM states and opcode classification helpers
// for the EX-stage ALU / multiply-divide unit.
package alu_muldiv_unit_pkg;

    localparam int OP_W = 5;
    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_ADD   = 5'd0;
    localparam opcode_t OP_SUB   = 5'd1;
    localparam opcode_t OP_OR    = 5'd2;
    localparam opcode_t OP_SRL   = 5'd4;
    localparam opcode_t OP_SLL   = 5'd5;
    localparam opcode_t OP_NOR   = 5'd12;
    localparam opcode_t OP_AND   = 5'd13;
    localparam opcode_t OP_SRA   = 5'd17;
    localparam opcode_t OP_SLT   = 5'd18;
    localparam opcode_t OP_SLTU  = 5'd19;
    localparam opcode_t OP_MULT  = 5'd20;
    localparam opcode_t OP_MULTU = 5'd21;
    localparam opcode_t OP_DIV   = 5'd22;
    localparam opcode_t OP_DIVU  = 5'd23;
    localparam opcode_t OP_MFHI  = 5'd24;
    localparam opcode_t OP_MFLO  = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input opcode_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_muldiv = 1'b1;
            default:                            is_muldiv = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input opcode_t op);
        case (op)
            OP_DIV, OP_DIVU: is_div = 1'b1;
            default:         is_div = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_md(input opcode_t op);
        case (op)
            OP_MULT, OP_DIV: is_signed_md = 1'b1;
            default:         is_signed_md = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Issue/result bundle between the EX-stage issuer (master) and the ALU unit (slave).
interface alu_muldiv_unit_if
    import alu_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
);
    logic                  in_valid;
    logic                  in_ready;
    opcode_t               alu_operation;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [SHAMT_W-1:0]    shamt;
    logic                  flush;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  zero;
    logic                  illegal;
    logic                  div_zero;
    logic                  busy;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_operation, a, b, shamt, flush,
        input  in_ready, out_valid, alu_data, zero, illegal, div_zero, busy, hi, lo
    );

    modport slave (
        input  in_valid, alu_operation, a, b, shamt, flush,
        output in_ready, out_valid, alu_data, zero, illegal, div_zero, busy, hi, lo
    );

endinterface

// File: rtl/alu_muldiv_unit_muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply / restoring divide on operand magnitudes,
// with sign fix-up applied combinationally to the final accumulator state.
module alu_muldiv_unit_muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  op_div,
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic                  div_zero
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic                    run_r, div_r, neg_a_r, neg_b_r, dz_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   hi_acc_r, lo_acc_r, opnd_b_r;

    logic                    neg_a_s, neg_b_s, div_fit_s;
    logic [DATA_WIDTH-1:0]   mag_a_s, mag_b_s, div_diff_s, step_hi_s, step_lo_s;
    logic [DATA_WIDTH:0]     mul_sum_s, div_shift_s;
    logic [2*DATA_WIDTH-1:0] prod_neg_s;

    assign neg_a_s    = op_signed & a[DATA_WIDTH-1];
    assign neg_b_s    = op_signed & b[DATA_WIDTH-1];
    assign mag_a_s    = neg_a_s ? -a : a;
    assign mag_b_s    = neg_b_s ? -b : b;
    assign prod_neg_s = -{hi_acc_r, lo_acc_r};

    // hi accumulates the product / holds the partial remainder; lo shifts out multiplier / in quotient
    assign mul_sum_s   = {1'b0, hi_acc_r} + (lo_acc_r[0] ? {1'b0, opnd_b_r} : {(DATA_WIDTH+1){1'b0}});
    assign div_shift_s = {hi_acc_r, lo_acc_r[DATA_WIDTH-1]};
    assign div_fit_s   = div_shift_s >= {1'b0, opnd_b_r};
    assign div_diff_s  = div_shift_s[DATA_WIDTH-1:0] - opnd_b_r;

    assign last     = run_r & (dz_r | (cnt_r == LAST_CNT));
    assign div_zero = dz_r;

    // Next accumulator values for one radix-2 step
    always_comb begin
        step_hi_s = hi_acc_r;
        step_lo_s = lo_acc_r;
        if (div_r) begin
            if (div_fit_s) begin
                step_hi_s = div_diff_s;
                step_lo_s = {lo_acc_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[DATA_WIDTH-1:0];
                step_lo_s = {lo_acc_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[DATA_WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_acc_r[DATA_WIDTH-1:1]};
        end
    end

    // Operand latch on start, then one step per cycle until the last step or a flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r    <= 1'b0;
            div_r    <= 1'b0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            dz_r     <= 1'b0;
            cnt_r    <= '0;
            hi_acc_r <= '0;
            lo_acc_r <= '0;
            opnd_b_r <= '0;
        end else if (start) begin
            run_r    <= 1'b1;
            div_r    <= op_div;
            neg_a_r  <= neg_a_s;
            neg_b_r  <= neg_b_s;
            dz_r     <= op_div & (b == '0);
            cnt_r    <= '0;
            hi_acc_r <= '0;
            lo_acc_r <= mag_a_s;
            opnd_b_r <= mag_b_s;
        end else if (flush) begin
            run_r <= 1'b0;
        end else if (run_r) begin
            if (!dz_r) begin
                hi_acc_r <= step_hi_s;
                lo_acc_r <= step_lo_s;
                cnt_r    <= cnt_r + CNT_W'(1);
            end
            if (last) begin
                run_r <= 1'b0;
            end
        end
    end

    // Sign fix-up; a zero divisor leaves the dividend magnitude untouched in lo_acc
    always_comb begin
        res_hi = hi_acc_r;
        res_lo = lo_acc_r;
        if (dz_r) begin
            res_hi = neg_a_r ? -lo_acc_r : lo_acc_r;
            res_lo = '1;
        end else if (div_r) begin
            res_lo = (neg_a_r ^ neg_b_r) ? -lo_acc_r : lo_acc_r;
            res_hi = neg_a_r ? -hi_acc_r : hi_acc_r;
        end else if (neg_a_r ^ neg_b_r) begin
            {res_hi, res_lo} = prod_neg_s;
        end else begin
            {res_hi, res_lo} = {hi_acc_r, lo_acc_r};
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU: registered single-cycle operations, HI/LO registers and the issue FSM
// that sequences the iterative multiply/divide engine.
module alu_muldiv_unit
    import alu_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    alu_muldiv_unit_if.slave bus
);
    state_t                state_r, state_s;
    logic                  in_ready_r, busy_r, out_valid_r, zero_r, illegal_r, div_zero_r;
    logic [DATA_WIDTH-1:0] data_r, hi_r, lo_r;

    logic                  accept_s, md_start_s, single_acc_s, commit_s;
    logic                  alu_ill_s, md_last_s, md_div_zero_s;
    logic [DATA_WIDTH-1:0] alu_res_s, md_hi_s, md_lo_s;
    logic [SHAMT_W-1:0]    shamt_s;

    assign shamt_s      = bus.shamt;
    assign accept_s     = bus.in_valid & in_ready_r;
    assign md_start_s   = accept_s & is_muldiv(bus.alu_operation);
    assign single_acc_s = accept_s & ~is_muldiv(bus.alu_operation);
    assign commit_s     = (state_r == ST_DONE) & ~bus.flush;

    alu_muldiv_unit_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start_s),
        .flush     (bus.flush),
        .op_div    (is_div(bus.alu_operation)),
        .op_signed (is_signed_md(bus.alu_operation)),
        .a         (bus.a),
        .b         (bus.b),
        .last      (md_last_s),
        .res_hi    (md_hi_s),
        .res_lo    (md_lo_s),
        .div_zero  (md_div_zero_s)
    );

    // Single-cycle result datapath
    always_comb begin
        alu_res_s = '0;
        alu_ill_s = 1'b0;
        case (bus.alu_operation)
            OP_ADD:  alu_res_s = bus.a + bus.b;
            OP_SUB:  alu_res_s = bus.a - bus.b;
            OP_OR:   alu_res_s = bus.a | bus.b;
            OP_SRL:  alu_res_s = bus.b >> shamt_s;
            OP_SLL:  alu_res_s = bus.b << shamt_s;
            OP_NOR:  alu_res_s = ~(bus.a | bus.b);
            OP_AND:  alu_res_s = bus.a & bus.b;
            OP_SRA:  alu_res_s = $unsigned($signed(bus.b) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_MFHI: alu_res_s = hi_r;
            OP_MFLO: alu_res_s = lo_r;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_res_s = '0;
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Issue FSM next state; flush wins over completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (md_start_s) state_s = ST_BUSY;
                else            state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (bus.flush)      state_s = ST_IDLE;
                else if (md_last_s) state_s = ST_DONE;
                else                state_s = ST_BUSY;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with handshake outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == ST_IDLE);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    // Result, flag and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            data_r      <= '0;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            div_zero_r  <= 1'b0;
            hi_r        <= '0;
            lo_r        <= '0;
        end else if (single_acc_s) begin
            out_valid_r <= 1'b1;
            data_r      <= alu_res_s;
            zero_r      <= (alu_res_s == '0);
            illegal_r   <= alu_ill_s;
            div_zero_r  <= 1'b0;
        end else if (commit_s) begin
            out_valid_r <= 1'b1;
            data_r      <= md_lo_s;
            zero_r      <= (md_lo_s == '0);
            illegal_r   <= 1'b0;
            div_zero_r  <= md_div_zero_s;
            hi_r        <= md_hi_s;
            lo_r        <= md_lo_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.alu_data  = data_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: directed corner cases plus randomized issue,
// checked against an arithmetic reference model of the opcode set.
module tb_alu_muldiv_unit;

    typedef struct {
        logic [31:0] data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        ill;
        logic        dz;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];
    logic [31:0] m_hi, m_lo;

    alu_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

    alu_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: returns expected response, updates model HI/LO; due holds latency in edges
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        logic [31:0] r;
        bit          md;
        bit          ill;
        r = 32'd0; md = 1'b0; ill = 1'b0; e.dz = 1'b0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a | b;
            5'd4:  r = b >> sh;
            5'd5:  r = b << sh;
            5'd12: r = ~(a | b);
            5'd13: r = a & b;
            5'd17: r = $signed(b) >>> sh;
            5'd18: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd19: r = (a < b) ? 32'd1 : 32'd0;
            5'd20: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = sp;
                md = 1'b1;
            end
            5'd21: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
                md = 1'b1;
            end
            5'd22, 5'd23: begin
                md = 1'b1;
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a; e.dz = 1'b1;
                end else if (op == 5'd22 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else if (op == 5'd22) begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            5'd24: r = m_hi;
            5'd25: r = m_lo;
            default: ill = 1'b1;
        endcase
        if (md) r = m_lo;
        e.data = r;
        e.zero = (r == 32'd0);
        e.ill  = ill;
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.due  = md ? (e.dz ? 2 : 33) : 0;
        return e;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit expect_out);
        exp_t e;
        int   guard;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_operation = op; bus.a = a; bus.b = b; bus.shamt = sh;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_timeout", 64'(guard >= 200), 64'd0);
        if (expect_out) begin
            e = model(op, a, b, sh);
            e.due = cyc + 1 + e.due;
            q.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
        chk({tag, "_data"},      64'(bus.alu_data),  64'd0);
        chk({tag, "_flags"},     64'({bus.zero, bus.illegal, bus.div_zero}), 64'd0);
        chk({tag, "_hi"},        64'(bus.hi),        64'd0);
        chk({tag, "_lo"},        64'(bus.lo),        64'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       rnd_val = 32'd0;
            1:       rnd_val = 32'hFFFF_FFFF;
            2:       rnd_val = 32'h8000_0000;
            3:       rnd_val = 32'($urandom_range(0, 15));
            default: rnd_val = $urandom;
        endcase
    endfunction

    // Monitor: every out_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid) begin
            chk("out_valid_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("latency",  64'(cyc),          64'(e.due));
                chk("data",     64'(bus.alu_data), 64'(e.data));
                chk("zero",     64'(bus.zero),     64'(e.zero));
                chk("illegal",  64'(bus.illegal),  64'(e.ill));
                chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                chk("hi",       64'(bus.hi),       64'(e.hi));
                chk("lo",       64'(bus.lo),       64'(e.lo));
            end
        end
    end

    logic [4:0] legal_ops [16] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd12, 5'd13, 5'd17,
                                   5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};

    initial begin
        int guard;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.alu_operation = 5'd0; bus.a = 32'd0; bus.b = 32'd0;
        bus.shamt = 5'd0; bus.flush = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        issue(5'd0, 32'd7, 32'd5, 5'd0, 1'b1);
        issue(5'd1, 32'd5, 32'd5, 5'd0, 1'b1);
        issue(5'd20, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b1);
        @(negedge clk);
        chk("mult_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mult_busy",     64'(bus.busy),     64'd1);
        issue(5'd21, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b1);
        issue(5'd24, 32'd0, 32'd0, 5'd0, 1'b1);
        issue(5'd25, 32'd0, 32'd0, 5'd0, 1'b1);
        issue(5'd22, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
        issue(5'd23, 32'd100, 32'd7, 5'd0, 1'b1);
        issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
        issue(5'd23, 32'd9, 32'd0, 5'd0, 1'b1);
        issue(5'd22, 32'hFFFF_FFF0, 32'd0, 5'd0, 1'b1);
        issue(5'd17, 32'd0, 32'h8000_0000, 5'd4, 1'b1);
        issue(5'd18, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        issue(5'd19, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        issue(5'd31, 32'd3, 32'd4, 5'd0, 1'b1);
        issue(5'd4, 32'd0, 32'h8000_0000, 5'd31, 1'b1);
        issue(5'd5, 32'd0, 32'h0000_0001, 5'd31, 1'b1);

        // Flush mid-MULT: no result, HI/LO keep their previous values
        issue(5'd20, 32'd12345, 32'd678, 5'd0, 1'b0);
        repeat (9) @(negedge clk);
        chk("pre_flush_in_ready", 64'(bus.in_ready), 64'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_busy",     64'(bus.busy),     64'd0);
        chk("flush_hi",       64'(bus.hi),       64'(m_hi));
        chk("flush_lo",       64'(bus.lo),       64'(m_lo));
        repeat (40) @(negedge clk);
        issue(5'd25, 32'd0, 32'd0, 5'd0, 1'b1);

        // Asynchronous reset in the middle of a DIV
        issue(5'd22, 32'd1000, 32'd3, 5'd0, 1'b0);
        repeat (5) @(negedge clk);
        #3 reset = 1'b1;
        #1 chk_reset_outputs("async_reset");
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        issue(5'd24, 32'd0, 32'd0, 5'd0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            logic [4:0] op;
            logic [31:0] ra, rb;
            if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 15)];
            else                           op = 5'($urandom_range(0, 31));
            ra = rnd_val();
            rb = rnd_val();
            issue(op, ra, rb, 5'($urandom_range(0, 31)), 1'b1);
        end

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
